// File: rtl/bv_tcam_engine.sv
// Bit-vector TCAM lookup: per-stride BV SRAM reads, per-segment AND, mode merge, priority encode; 5-cycle latency.
// One lookup per cycle while ready; lookups offered during the post-reset clear sweep are dropped and counted.
module bv_tcam_engine #(
  parameter int STRIDE       = 4,
  parameter int SRAM_NUM     = 32,
  parameter int SEG_NUM      = 4,
  parameter int MODE_WIDTH   = 2,
  parameter int RESULT_WIDTH = 32,
  localparam int AW  = STRIDE + MODE_WIDTH,
  localparam int IW  = $clog2(RESULT_WIDTH),
  localparam int SW  = $clog2(SRAM_NUM),
  localparam int SPS = SRAM_NUM / SEG_NUM
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic                       din_val,
  input  logic [STRIDE*SRAM_NUM-1:0] din,
  input  logic [MODE_WIDTH-1:0]      bus_mode,
  input  logic                       cfg_en,
  input  logic                       cfg_bcast,
  input  logic [SW-1:0]              cfg_sel,
  input  logic [AW-1:0]              cfg_addr,
  input  logic [RESULT_WIDTH-1:0]    cfg_data,
  output logic                       dout_val,
  output logic [MODE_WIDTH-1:0]      dout_mode,
  output logic [SEG_NUM-1:0]         dout_hit,
  output logic [SEG_NUM*IW-1:0]      dout_idx,
  output logic [15:0]                drop_cnt
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic                    bcast;
    logic [SW-1:0]           sel;
    logic [AW-1:0]           addr;
    logic [RESULT_WIDTH-1:0] data;
  } cfg_t;

  logic [0:0]    state;
  logic [AW-1:0] clr_addr;
  logic          accept;

  assign ready  = (state == ST_RUN);
  assign accept = din_val && ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      clr_addr <= '0;
    end else if (state == ST_INIT) begin
      clr_addr <= clr_addr + AW'(1);
      if (clr_addr == {AW{1'b1}}) state <= ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (din_val && !ready && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Config writes land one cycle late so they coincide with the S2 read of a
  // same-cycle lookup, which therefore sees the old word.
  logic cw_vld;
  cfg_t cw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cw_vld <= 1'b0;
      cw     <= '0;
    end else begin
      cw_vld <= cfg_en && ready;
      if (cfg_en && ready) cw <= {cfg_bcast, cfg_sel, cfg_addr, cfg_data};
    end
  end

  logic [AW-1:0]           wr_addr;
  logic [RESULT_WIDTH-1:0] wr_data;

  always_comb begin
    wr_addr = cw.addr;
    wr_data = cw.data;
    if (state == ST_INIT) begin
      wr_addr = clr_addr;
      wr_data = '0;
    end
  end

  // S1: per-SRAM address and mode
  logic                         s1_vld;
  logic [MODE_WIDTH-1:0]        s1_mode;
  logic [SRAM_NUM-1:0][AW-1:0]  s1_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_mode <= '0;
      s1_addr <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_mode <= bus_mode;
        for (int i = 0; i < SRAM_NUM; i++) s1_addr[i] <= {bus_mode, din[STRIDE*i +: STRIDE]};
      end
    end
  end

  // S2: synchronous BV SRAM reads
  logic [RESULT_WIDTH-1:0] rd_vec [SRAM_NUM];

  for (genvar g = 0; g < SRAM_NUM; g++) begin : g_sram
    logic [RESULT_WIDTH-1:0] mem [2**AW];
    logic [RESULT_WIDTH-1:0] rd_q;
    logic                    wr_en;

    assign wr_en     = (state == ST_INIT) || (cw_vld && (cw.bcast || cw.sel == SW'(g)));
    assign rd_vec[g] = rd_q;

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (s1_vld) rd_q <= mem[s1_addr[g]];
    end
  end

  logic                  s2_vld;
  logic [MODE_WIDTH-1:0] s2_mode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld  <= 1'b0;
      s2_mode <= '0;
    end else begin
      s2_vld  <= s1_vld;
      s2_mode <= s1_mode;
    end
  end

  // S3: per-segment AND
  logic [SEG_NUM-1:0][RESULT_WIDTH-1:0] seg_and;
  logic [SEG_NUM-1:0][RESULT_WIDTH-1:0] s3_vec;
  logic                                 s3_vld;
  logic [MODE_WIDTH-1:0]                s3_mode;

  always_comb begin
    seg_and = '1;
    for (int s = 0; s < SEG_NUM; s++)
      for (int k = 0; k < SPS; k++)
        seg_and[s] = seg_and[s] & rd_vec[s*SPS + k];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_vld  <= 1'b0;
      s3_mode <= '0;
      s3_vec  <= '0;
    end else begin
      s3_vld  <= s2_vld;
      s3_mode <= s2_mode;
      if (s2_vld) s3_vec <= seg_and;
    end
  end

  // S4: mode merge
  logic [RESULT_WIDTH-1:0]              all_and;
  logic [SEG_NUM-1:0][RESULT_WIDTH-1:0] mrg;
  logic [SEG_NUM-1:0][RESULT_WIDTH-1:0] s4_vec;
  logic                                 s4_vld;
  logic [MODE_WIDTH-1:0]                s4_mode;

  always_comb begin
    all_and = '1;
    mrg     = '0;
    for (int s = 0; s < SEG_NUM; s++) all_and = all_and & s3_vec[s];
    for (int s = 0; s < SEG_NUM; s++) begin
      if (s3_mode == '0)                   mrg[s] = s3_vec[s];
      else if (s3_mode == MODE_WIDTH'(1))  mrg[s] = s3_vec[2*(s/2)] & s3_vec[2*(s/2) + 1];
      else                                 mrg[s] = all_and;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s4_vld  <= 1'b0;
      s4_mode <= '0;
      s4_vec  <= '0;
    end else begin
      s4_vld  <= s3_vld;
      s4_mode <= s3_mode;
      if (s3_vld) s4_vec <= mrg;
    end
  end

  // S5: lowest-set-bit priority encode; outputs hold between results
  logic [SEG_NUM-1:0]    enc_hit;
  logic [SEG_NUM*IW-1:0] enc_idx;

  always_comb begin
    enc_hit = '0;
    enc_idx = '0;
    for (int s = 0; s < SEG_NUM; s++) begin
      enc_hit[s] = |s4_vec[s];
      for (int b = RESULT_WIDTH-1; b >= 0; b--)
        if (s4_vec[s][b]) enc_idx[IW*s +: IW] = IW'(b);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_val  <= 1'b0;
      dout_mode <= '0;
      dout_hit  <= '0;
      dout_idx  <= '0;
    end else begin
      dout_val <= s4_vld;
      if (s4_vld) begin
        dout_mode <= s4_mode;
        dout_hit  <= enc_hit;
        dout_idx  <= enc_idx;
      end
    end
  end

endmodule

// File: tb/tb_bv_tcam_engine.sv
// Directed bench for bv_tcam_engine at default parameters; expected results are
// queued at issue time and compared (with exact latency) when dout_val appears.
module tb_bv_tcam_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ready;
  logic         din_val;
  logic [127:0] din;
  logic [1:0]   bus_mode;
  logic         cfg_en;
  logic         cfg_bcast;
  logic [4:0]   cfg_sel;
  logic [5:0]   cfg_addr;
  logic [31:0]  cfg_data;
  logic         dout_val;
  logic [1:0]   dout_mode;
  logic [3:0]   dout_hit;
  logic [19:0]  dout_idx;
  logic [15:0]  drop_cnt;

  bv_tcam_engine dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .din_val   (din_val),
    .din       (din),
    .bus_mode  (bus_mode),
    .cfg_en    (cfg_en),
    .cfg_bcast (cfg_bcast),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .dout_val  (dout_val),
    .dout_mode (dout_mode),
    .dout_hit  (dout_hit),
    .dout_idx  (dout_idx),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [1:0]  mode;
    logic [3:0]  hit;
    logic [19:0] idx;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   fails  = 0;
  int   total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] nib(input logic [3:0] n);
    return {32{n}};
  endfunction

  function automatic logic [19:0] idx4(input logic [4:0] a0, input logic [4:0] a1,
                                       input logic [4:0] a2, input logic [4:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && dout_val) begin
      if (sb.size() == 0) begin
        chk("unexpected_dout_val", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc, e.due);
        chk("dout_mode", {30'd0, dout_mode}, {30'd0, e.mode});
        chk("dout_hit", {28'd0, dout_hit}, {28'd0, e.hit});
        chk("dout_idx", {12'd0, dout_idx}, {12'd0, e.idx});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [127:0] key, input logic [1:0] mode,
                       input logic [3:0] hit, input logic [19:0] idx);
    exp_t e;
    e.due  = cyc + 5;
    e.mode = mode;
    e.hit  = hit;
    e.idx  = idx;
    sb.push_back(e);
    din_val  = 1'b1;
    din      = key;
    bus_mode = mode;
    step();
    din_val = 1'b0;
  endtask

  task automatic cfg(input logic bc, input logic [4:0] sel, input logic [5:0] addr,
                     input logic [31:0] data);
    cfg_en    = 1'b1;
    cfg_bcast = bc;
    cfg_sel   = sel;
    cfg_addr  = addr;
    cfg_data  = data;
    step();
    cfg_en = 1'b0;
  endtask

  task automatic wait_ready(input int rel, input string tag);
    int n = 0;
    while (!ready && n < 200) begin
      step();
      n++;
    end
    chk(tag, cyc - rel, 64);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb.size(), 0);
    step();
  endtask

  initial begin
    int rel;
    logic seen;
    din_val = 1'b0; din = '0; bus_mode = '0;
    cfg_en = 1'b0; cfg_bcast = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_dout_val", dout_val, 0);
    chk("rst_dout_hit", dout_hit, 0);
    chk("rst_dout_idx", dout_idx, 0);
    chk("rst_dout_mode", dout_mode, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("init_ready_low", ready, 0);
    rst = 1'b1;
    rel = cyc;
    wait_ready(rel, "init_len");

    issue(nib(4'h0), 2'd0, 4'b0000, idx4(0, 0, 0, 0));

    cfg(1'b1, 5'd0, 6'h03, 32'h0000_0010);
    issue(nib(4'h3), 2'd0, 4'b1111, idx4(4, 4, 4, 4));

    cfg(1'b1, 5'd0, 6'h05, 32'hFFFF_FFFF);
    cfg(1'b0, 5'd0, 6'h05, 32'h0000_0100);
    cfg(1'b0, 5'd8, 6'h05, 32'h8000_0000);
    cfg(1'b1, 5'd0, 6'h15, 32'hFFFF_FFFF);
    cfg(1'b0, 5'd0, 6'h15, 32'h0000_0100);
    cfg(1'b0, 5'd8, 6'h15, 32'h8000_0000);
    cfg(1'b1, 5'd0, 6'h35, 32'hFFFF_FFFF);
    cfg(1'b0, 5'd31, 6'h35, 32'h0000_00F0);
    issue(nib(4'h5), 2'd0, 4'b1111, idx4(8, 31, 0, 0));
    issue(nib(4'h5), 2'd1, 4'b1100, idx4(0, 0, 0, 0));
    issue(nib(4'h5), 2'd2, 4'b0000, idx4(0, 0, 0, 0));
    issue(nib(4'h5), 2'd3, 4'b1111, idx4(4, 4, 4, 4));
    drain("drain_modes");

    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) issue(nib(4'h3), 2'd0, 4'b1111, idx4(4, 4, 4, 4));
      else            issue(nib(4'h3), 2'd2, 4'b0000, idx4(0, 0, 0, 0));
    end
    drain("drain_b2b");

    // Read-before-write on a same-cycle lookup and config write
    cfg(1'b1, 5'd0, 6'h03, 32'h0000_0030);
    cfg(1'b0, 5'd0, 6'h03, 32'h0000_0010);
    cfg_en = 1'b1; cfg_bcast = 1'b0; cfg_sel = 5'd0; cfg_addr = 6'h03; cfg_data = 32'h0000_0020;
    issue(nib(4'h3), 2'd0, 4'b1111, idx4(4, 4, 4, 4));
    cfg_en = 1'b0;
    issue(nib(4'h3), 2'd0, 4'b1111, idx4(5, 4, 4, 4));
    drain("drain_collision");

    // Drops during INIT, then a reset mid-INIT
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      din_val = 1'b1;
      din     = nib(4'h3);
      step();
      din_val = 1'b0;
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (dout_val) seen = 1'b1;
    end
    chk("no_dout_during_init", seen, 0);
    chk("drop_cnt", drop_cnt, 3);
    rst = 1'b0;
    #1;
    chk("drop_cnt_rst", drop_cnt, 0);
    chk("ready_rst_mid_init", ready, 0);
    @(negedge clk);
    rst = 1'b1;
    rel = cyc;
    wait_ready(rel, "init_restart_len");

    // Reset with two lookups in flight
    issue(nib(4'h3), 2'd0, 4'b1111, idx4(5, 4, 4, 4));
    issue(nib(4'h3), 2'd0, 4'b1111, idx4(5, 4, 4, 4));
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    chk("rst_flight_dout_val", dout_val, 0);
    chk("rst_flight_ready", ready, 0);
    @(negedge clk);
    rst = 1'b1;
    rel = cyc;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (dout_val) seen = 1'b1;
    end
    chk("no_dout_after_rst", seen, 0);
    wait_ready(rel, "init_after_flight_len");

    issue(nib(4'h3), 2'd0, 4'b0000, idx4(0, 0, 0, 0));
    drain("drain_final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
